// File: rtl/alu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl_if
// Brief    : Instruction, ALU, register-file load/debug bundle for alu_issue_ctrl
// Revision : 1.0 - initial release
// ============================================================================
interface alu_issue_ctrl_if #(
    parameter int LEN = 16
);
    logic           instr_valid;
    logic           instr_ready;
    logic [3:0]     instr_op;
    logic [3:0]     instr_shamt;
    logic [3:0]     instr_rd;
    logic [3:0]     instr_rs2;
    logic [3:0]     instr_rs3;

    logic [LEN-1:0] alu_r2;
    logic [LEN-1:0] alu_r3;
    logic [3:0]     alu_opcode;
    logic [3:0]     alu_shift;
    logic           alu_execute;
    logic [LEN-1:0] alu_r1;
    logic [3:0]     alu_flags;

    logic           done;
    logic           done_err;
    logic [3:0]     flags_q;

    logic           ld_en;
    logic [3:0]     ld_addr;
    logic [LEN-1:0] ld_data;
    logic [3:0]     dbg_addr;
    logic [LEN-1:0] dbg_data;

    // Controller side
    modport slave (
        input  instr_valid, instr_op, instr_shamt, instr_rd, instr_rs2, instr_rs3,
        output instr_ready,
        output alu_r2, alu_r3, alu_opcode, alu_shift, alu_execute,
        input  alu_r1, alu_flags,
        output done, done_err, flags_q,
        input  ld_en, ld_addr, ld_data, dbg_addr,
        output dbg_data
    );

    // Fetch/decode + ALU side
    modport master (
        output instr_valid, instr_op, instr_shamt, instr_rd, instr_rs2, instr_rs3,
        input  instr_ready,
        input  alu_r2, alu_r3, alu_opcode, alu_shift, alu_execute,
        output alu_r1, alu_flags,
        input  done, done_err, flags_q,
        output ld_en, ld_addr, ld_data, dbg_addr,
        input  dbg_data
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl
// Brief    : IDLE/EXEC/WB sequencer driving a combinational 16-bit ALU,
//            with a 16x16 register file and committed flags register.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
    parameter int LEN      = 16,
    parameter int MULT_LAT = 3
) (
    input  wire logic        clk,
    input  wire logic        reset,
    alu_issue_ctrl_if.slave  bus
);

    localparam int         c_CNT_W   = (MULT_LAT < 2) ? 1 : $clog2(MULT_LAT + 1);
    localparam logic [3:0] c_OP_SUB  = 4'd1;
    localparam logic [3:0] c_OP_MULT = 4'd2;
    localparam logic [3:0] c_OP_CMP  = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t               r_state;
    logic [LEN-1:0]       r_rf [16];
    logic [LEN-1:0]       r_opa;
    logic [LEN-1:0]       r_opb;
    logic [3:0]           r_alu_op;
    logic [3:0]           r_shamt;
    logic [3:0]           r_rd;
    logic                 r_is_cmp;
    logic                 r_illegal;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_exec;
    logic                 r_done;
    logic                 r_done_err;
    logic [3:0]           r_flags;

    logic                 w_op_illegal;

    assign w_op_illegal = (bus.instr_op > c_OP_CMP);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            for (int i = 0; i < 16; i++) r_rf[i] <= '0;
            r_opa      <= '0;
            r_opb      <= '0;
            r_alu_op   <= '0;
            r_shamt    <= '0;
            r_rd       <= '0;
            r_is_cmp   <= 1'b0;
            r_illegal  <= 1'b0;
            r_cnt      <= '0;
            r_exec     <= 1'b0;
            r_done     <= 1'b0;
            r_done_err <= 1'b0;
            r_flags    <= '0;
        end else begin
            r_done     <= 1'b0;
            r_done_err <= 1'b0;

            // Debug load first so a same-cycle writeback to the same index overrides it
            if (bus.ld_en) r_rf[bus.ld_addr] <= bus.ld_data;

            case (r_state)
                S_IDLE: begin
                    if (bus.instr_valid) begin
                        r_opa     <= r_rf[bus.instr_rs2];
                        r_opb     <= r_rf[bus.instr_rs3];
                        r_alu_op  <= (bus.instr_op == c_OP_CMP) ? c_OP_SUB : bus.instr_op;
                        r_shamt   <= bus.instr_shamt;
                        r_rd      <= bus.instr_rd;
                        r_is_cmp  <= (bus.instr_op == c_OP_CMP);
                        r_illegal <= w_op_illegal;
                        r_exec    <= 1'b1;
                        if (w_op_illegal) begin
                            r_state    <= S_WB;
                            r_done     <= 1'b1;
                            r_done_err <= 1'b1;
                        end else begin
                            r_cnt   <= (bus.instr_op == c_OP_MULT) ? c_CNT_W'(MULT_LAT)
                                                                  : c_CNT_W'(1);
                            r_state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    r_cnt <= r_cnt - c_CNT_W'(1);
                    if (r_cnt <= c_CNT_W'(1)) begin
                        r_state <= S_WB;
                        r_done  <= 1'b1;
                    end
                end
                S_WB: begin
                    if (!r_illegal) begin
                        r_flags <= bus.alu_flags;
                        if (!r_is_cmp) r_rf[r_rd] <= bus.alu_r1;
                    end
                    r_exec  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_exec  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.instr_ready = (r_state == S_IDLE);
    assign bus.alu_r2      = r_opa;
    assign bus.alu_r3      = r_opb;
    assign bus.alu_opcode  = r_alu_op;
    assign bus.alu_shift   = r_shamt;
    assign bus.alu_execute = r_exec;
    assign bus.done        = r_done;
    assign bus.done_err    = r_done_err;
    assign bus.flags_q     = r_flags;
    assign bus.dbg_data    = r_rf[bus.dbg_addr];

endmodule
`default_nettype wire
